// File: rtl/md_unit_seq.sv
// Iterative multiply/divide sequencer with HI/LO registers: radix-2 shift-add
// multiply and restoring divide, one bit per cycle, plus mthi/mtlo writes.
module md_unit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;

  logic            is_div, sa, sb, bz;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] bmag;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   mul_add;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;
  logic            sgn_in;

  // Magnitude of a two's-complement operand (most-negative value maps to 2^(WIDTH-1)).
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  assign busy   = (state != IDLE);
  assign sgn_in = ~op[0];

  always_comb begin
    rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff    = {1'b0, rem_sh} - {2'b00, bmag};
    mul_sum = rem + {1'b0, bmag};
    mul_add = quo[0] ? mul_sum : rem;
    prod    = cond_neg2({rem[WIDTH-1:0], quo}, sa ^ sb);
    if (is_div) begin
      res_lo = bz ? '1 : cond_neg(quo, sa ^ sb);
      res_hi = cond_neg(rem[WIDTH-1:0], sa);
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX);
      if (state == IDLE && start) cnt <= '0;
      else if (state == CALC)     cnt <= cnt + 1'b1;
      if (state == FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

  // Iteration datapath: {rem,quo} is the shift pair for both multiply and divide
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      is_div <= op[1];
      sa     <= sgn_in & a[WIDTH-1];
      sb     <= sgn_in & b[WIDTH-1];
      bz     <= (b == '0);
      rem    <= '0;
      quo    <= mag(a, sgn_in & a[WIDTH-1]);
      bmag   <= mag(b, sgn_in & b[WIDTH-1]);
    end else if (state == CALC) begin
      if (is_div) begin
        if (!diff[WIDTH+1]) begin
          rem <= diff[WIDTH:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= rem_sh;
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end else begin
        rem <= {1'b0, mul_add[WIDTH:1]};
        quo <= {mul_add[0], quo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_md_unit_seq.sv
// Bench for md_unit_seq: directed corner cases plus random ops checked
// against an arithmetic reference model of mult/multu/div/divu.
module tb_md_unit_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           errors = 0;
  int           checks = 0;
  logic [63:0]  exp_r;
  logic [W-1:0] saved_hi;

  md_unit_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: returns {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      px, py;
    logic [63:0] ux, uy;
    int          sx, sy, q, r;
    case (o)
      2'b00: begin
        px = $signed(x);
        py = $signed(y);
        return 64'(px * py);
      end
      2'b01: begin
        ux = {32'd0, x};
        uy = {32'd0, y};
        return ux * uy;
      end
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sx = $signed(x);
        sy = $signed(y);
        q = sx / sy;
        r = sx % sy;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Called at a negedge; leaves the bench at the first negedge after the start edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit wr);
    start = 1'b1; op = o; a = x; b = y; exp_r = model(o, x, y);
    hi_we = wr; lo_we = wr; wdata = $urandom;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  // Counts busy negedges, then checks the done cycle and the result.
  task automatic finish_op(input string tag, input int n0);
    int n;
    n = n0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " hilo"}, {hi, lo}, exp_r);
  endtask

  initial begin
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic corners
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    finish_op("multu_max", 0);
    check("multu_max hilo_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    check("done_drop", 64'(done), 64'd0);

    launch(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
    finish_op("mult_neg", 0);
    check("mult_neg hilo_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    launch(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    finish_op("mult_minmin", 0);
    check("mult_minmin hilo_const", {hi, lo}, 64'h4000_0000_0000_0000);
    launch(2'b11, 32'd7, 32'd2, 1'b0);
    finish_op("divu_7_2", 0);
    check("divu_7_2 hilo_const", {hi, lo}, {32'd1, 32'd3});
    launch(2'b10, 32'h0000_1234, 32'd0, 1'b0);
    finish_op("div_by_zero", 0);
    check("div_by_zero hilo_const", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});
    launch(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0);
    finish_op("div_neg_by_zero", 0);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    finish_op("div_overflow", 0);
    check("div_overflow hilo_const", {hi, lo}, {32'd0, 32'h8000_0000});

    // Disturbance while busy, then start in the done cycle
    launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    finish_op("div_disturbed", 1);
    check("div_disturbed hilo_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    launch(2'b11, 32'd100, 32'd7, 1'b0);
    finish_op("chained_divu", 0);
    @(negedge clk);
    check("chained done_drop", 64'(done), 64'd0);

    // mtlo / mthi in IDLE
    saved_hi = hi;
    lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo lo", 64'(lo), 64'hA5A5_A5A5);
    check("mtlo hi_kept", 64'(hi), 64'(saved_hi));
    hi_we = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi hi", 64'(hi), 64'h0BAD_F00D);

    // Write together with start: result wins
    launch(2'b00, 32'd1234, 32'hFFFF_FF00, 1'b1);
    finish_op("mult_with_write", 0);

    // Random ops
    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      logic [1:0]  o;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (i % 8 == 0) y = 32'd0;
      if (i % 8 == 1) y = 32'($urandom_range(1, 15));
      if (i % 8 == 2) y = 32'hFFFF_FFFF;
      if (i % 8 == 3) x = 32'h8000_0000;
      launch(o, x, y, (i % 5 == 0));
      finish_op("random", 0);
      @(negedge clk);
      check("random done_drop", 64'(done), 64'd0);
    end

    // Asynchronous reset mid-operation at cnt=10
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset hilo", {hi, lo}, 64'd0);
    launch(2'b01, 32'd6, 32'd7, 1'b0);
    finish_op("multu_6_7", 0);
    check("multu_6_7 hilo_const", {hi, lo}, 64'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
